// File: rtl/psp_trace_pkg.sv
// Shared types for the PSP RVFI trace path: the record layout drained to
// checkers/loggers and the halt-loop detector states.
package psp_trace_pkg;

  localparam int XLEN    = 32;
  localparam int ORDER_W = 64;

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [XLEN-1:0]    pc_r;
    logic [XLEN-1:0]    pc_w;
    logic [XLEN-1:0]    insn;
    logic [4:0]         rd;
    logic [XLEN-1:0]    rd_wdata;
    logic [XLEN-1:0]    maddr;
    logic [3:0]         rmask;
    logic [3:0]         wmask;
  } trace_rec_t;

  typedef enum logic {
    RUN,
    HALT
  } halt_state_t;

endpackage

// File: rtl/rvfi_trace_fifo.sv
// Circular record buffer: up to NRET writes per cycle packed into consecutive
// slots in channel order, one read per cycle, with an occupancy count.
module rvfi_trace_fifo
  import psp_trace_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [NRET-1:0]            wr_valid,
  input  trace_rec_t [NRET-1:0]      wr_rec,
  input  logic [$clog2(DEPTH):0]     wr_cnt,
  input  logic                       pop,
  output trace_rec_t                 rd_rec,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic [AW-1:0]  slot [NRET];
  logic [AW-1:0]  slot_acc;

  // Valid channels are compacted: the k-th valid one lands at wr_ptr + k.
  always_comb begin
    slot_acc = '0;
    for (int i = 0; i < NRET; i++) begin
      slot[i] = wr_ptr_reg + slot_acc;
      if (wr_valid[i]) slot_acc = slot_acc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++) begin
      if (push && wr_valid[i]) mem[slot[i]] <= wr_rec[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + wr_cnt[AW-1:0];
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (push ? wr_cnt : '0) - {{AW{1'b0}}, pop};
    end
  end

  assign rd_rec = mem[rd_ptr_reg];
  assign count  = count_reg;

endmodule

// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement collector: stamps orders, admits whole retire groups into the
// record FIFO or drops them with statistics, and watches for a jump-to-self halt.
module rvfi_trace_buffer
  import psp_trace_pkg::*;
#(
  parameter int NRET        = 2,
  parameter int DEPTH       = 16,
  parameter int HALT_REPEAT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NRET-1:0]    rvfi_valid,
  input  logic [NRET*32-1:0] rvfi_insn,
  input  logic [NRET*32-1:0] rvfi_pc_rdata,
  input  logic [NRET*32-1:0] rvfi_pc_wdata,
  input  logic [NRET*5-1:0]  rvfi_rd_addr,
  input  logic [NRET*32-1:0] rvfi_rd_wdata,
  input  logic [NRET*32-1:0] rvfi_mem_addr,
  input  logic [NRET*4-1:0]  rvfi_mem_rmask,
  input  logic [NRET*4-1:0]  rvfi_mem_wmask,
  output logic               out_valid,
  input  logic               out_ready,
  output trace_rec_t         out_rec,
  output logic [63:0]        retired,
  output logic               overflow,
  output logic [15:0]        drop_count,
  output logic               halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  trace_rec_t [NRET-1:0] rec;
  logic [CW-1:0]         offs [NRET];
  logic [CW-1:0]         nvalid;
  logic [CW-1:0]         count;
  logic                  accept;
  logic                  pop;
  logic [63:0]           retired_reg;
  logic                  overflow_reg;
  logic [15:0]           drop_count_reg;
  logic [16:0]           drop_sum;
  halt_state_t           state_reg;
  logic                  halted_reg;
  logic [2:0]            loop_cnt_reg;
  logic [2:0]            loop_cnt_next;
  logic                  loop_hit;

  always_comb begin
    nvalid = '0;
    for (int i = 0; i < NRET; i++) begin
      offs[i] = nvalid;
      if (rvfi_valid[i]) nvalid = nvalid + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NRET; gi++) begin : g_rec
      assign rec[gi] = '{
        order:    retired_reg + ORDER_W'(offs[gi]),
        pc_r:     rvfi_pc_rdata[gi*32 +: 32],
        pc_w:     rvfi_pc_wdata[gi*32 +: 32],
        insn:     rvfi_insn[gi*32 +: 32],
        rd:       rvfi_rd_addr[gi*5 +: 5],
        rd_wdata: rvfi_rd_wdata[gi*32 +: 32],
        maddr:    rvfi_mem_addr[gi*32 +: 32],
        rmask:    rvfi_mem_rmask[gi*4 +: 4],
        wmask:    rvfi_mem_wmask[gi*4 +: 4]
      };
    end
  endgenerate

  // Space is judged on pre-pop occupancy, so a pop never makes room for a same-cycle push.
  assign accept    = (nvalid != '0) && (nvalid <= (CW'(DEPTH) - count));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign drop_sum  = {1'b0, drop_count_reg} + 17'(nvalid);

  rvfi_trace_fifo #(
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .wr_valid (rvfi_valid),
    .wr_rec   (rec),
    .wr_cnt   (nvalid),
    .pop      (pop),
    .rd_rec   (out_rec),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_reg    <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      retired_reg <= retired_reg + 64'(nvalid);
      if ((nvalid != '0) && !accept) begin
        overflow_reg   <= 1'b1;
        drop_count_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

  // Walk channels oldest-first so a loop run can complete mid-group.
  always_comb begin
    loop_cnt_next = loop_cnt_reg;
    loop_hit      = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        if (rvfi_pc_wdata[i*32 +: 32] == rvfi_pc_rdata[i*32 +: 32]) begin
          if (loop_cnt_next < 3'(HALT_REPEAT)) loop_cnt_next = loop_cnt_next + 1'b1;
          if (loop_cnt_next == 3'(HALT_REPEAT)) loop_hit = 1'b1;
        end else begin
          loop_cnt_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      halted_reg   <= 1'b0;
      loop_cnt_reg <= '0;
    end else begin
      loop_cnt_reg <= loop_cnt_next;
      case (state_reg)
        RUN: begin
          if (loop_hit) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end
        end
        default: state_reg <= HALT;
      endcase
    end
  end

  assign retired    = retired_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;
  assign halted     = halted_reg;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed bench for rvfi_trace_buffer: stimulus pushes expected records into a
// queue, a negedge monitor pops and compares every accepted output record.
module tb_rvfi_trace_buffer;
  import psp_trace_pkg::*;

  localparam int NRET  = 2;
  localparam int DEPTH = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NRET-1:0]    rvfi_valid = '0;
  logic [NRET*32-1:0] rvfi_insn = '0;
  logic [NRET*32-1:0] rvfi_pc_rdata = '0;
  logic [NRET*32-1:0] rvfi_pc_wdata = '0;
  logic [NRET*5-1:0]  rvfi_rd_addr = '0;
  logic [NRET*32-1:0] rvfi_rd_wdata = '0;
  logic [NRET*32-1:0] rvfi_mem_addr = '0;
  logic [NRET*4-1:0]  rvfi_mem_rmask = '0;
  logic [NRET*4-1:0]  rvfi_mem_wmask = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  trace_rec_t         out_rec;
  logic [63:0]        retired;
  logic               overflow;
  logic [15:0]        drop_count;
  logic               halted;

  int          checks = 0;
  int          errors = 0;
  longint      next_order = 0;
  trace_rec_t  exp_q [$];
  bit          stalled = 1'b0;
  trace_rec_t  held;

  rvfi_trace_buffer #(.NRET(NRET), .DEPTH(DEPTH), .HALT_REPEAT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .rvfi_valid     (rvfi_valid),
    .rvfi_insn      (rvfi_insn),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_pc_wdata  (rvfi_pc_wdata),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_mem_addr  (rvfi_mem_addr),
    .rvfi_mem_rmask (rvfi_mem_rmask),
    .rvfi_mem_wmask (rvfi_mem_wmask),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rec        (out_rec),
    .retired        (retired),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic trace_rec_t mk(input logic [31:0] pc, input longint order, input bit sl);
    trace_rec_t r;
    r.order    = 64'(order);
    r.pc_r     = pc;
    r.pc_w     = sl ? pc : pc + 32'd4;
    r.insn     = 32'h0000_0013 ^ pc;
    r.rd       = pc[6:2];
    r.rd_wdata = ~pc;
    r.maddr    = pc + 32'h1000;
    r.rmask    = 4'hF;
    r.wmask    = pc[5:2];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One retire group; keep=1 means the bench expects it to be stored.
  task automatic issue(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input bit keep, input bit sl);
    logic [31:0] pcs [2];
    trace_rec_t r;
    pcs[0] = pc0;
    pcs[1] = pc1;
    rvfi_valid = v;
    for (int i = 0; i < NRET; i++) begin
      r = mk(pcs[i], next_order, sl);
      rvfi_pc_rdata[i*32 +: 32]  = r.pc_r;
      rvfi_pc_wdata[i*32 +: 32]  = r.pc_w;
      rvfi_insn[i*32 +: 32]      = r.insn;
      rvfi_rd_addr[i*5 +: 5]     = r.rd;
      rvfi_rd_wdata[i*32 +: 32]  = r.rd_wdata;
      rvfi_mem_addr[i*32 +: 32]  = r.maddr;
      rvfi_mem_rmask[i*4 +: 4]   = r.rmask;
      rvfi_mem_wmask[i*4 +: 4]   = r.wmask;
      if (v[i]) begin
        if (keep) exp_q.push_back(r);
        next_order++;
      end
    end
    @(posedge clk); #1;
    rvfi_valid = '0;
  endtask

  task automatic do_reset();
    rvfi_valid = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    next_order = 0;
  endtask

  task automatic drain(input bit toggle);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((out_valid || exp_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      n++;
    end
    out_ready = 1'b1;
    chk("drain_complete", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) begin
        checks++;
        if (out_rec !== held) begin
          errors++;
          $display("FAIL stall_stable: order %0d changed to %0d while stalled", held.order, out_rec.order);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_record: got order %0d, expected none", out_rec.order);
        end else begin
          trace_rec_t e;
          e = exp_q.pop_front();
          if (out_rec !== e) begin
            errors++;
            $display("FAIL record: got order %0d pc_r %0h rec %0h expected order %0d pc_r %0h rec %0h",
                     out_rec.order, out_rec.pc_r, out_rec, e.order, e.pc_r, e);
          end else begin
            $display("ok   record: order %0d pc_r %0h", out_rec.order, out_rec.pc_r);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_rec;
    end
  end

  initial begin
    out_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_retired", retired, 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_drop_count", 64'(drop_count), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);

    // Single and dual retire
    issue(2'b01, 32'h60, 32'h0, 1'b1, 1'b0);
    chk("single_retired", retired, 64'd1);
    drain(1'b0);
    do_reset();
    issue(2'b11, 32'h60, 32'h64, 1'b1, 1'b0);
    chk("dual_retired", retired, 64'd2);
    issue(2'b10, 32'h0, 32'h68, 1'b1, 1'b0);
    chk("ch1_only_retired", retired, 64'd3);
    drain(1'b0);

    // Halt detection
    do_reset();
    for (int i = 0; i < 3; i++) issue(2'b01, 32'h80, 32'h0, 1'b1, 1'b1);
    chk("halt_after_3", 64'(halted), 64'd0);
    issue(2'b01, 32'h80, 32'h0, 1'b1, 1'b1);
    chk("halt_after_4", 64'(halted), 64'd1);
    issue(2'b01, 32'h84, 32'h0, 1'b1, 1'b0);
    chk("halt_sticky", 64'(halted), 64'd1);
    drain(1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) issue(2'b01, 32'h80, 32'h0, 1'b1, 1'b1);
    issue(2'b01, 32'h84, 32'h0, 1'b1, 1'b0);
    issue(2'b01, 32'h80, 32'h0, 1'b1, 1'b1);
    chk("halt_broken_run", 64'(halted), 64'd0);
    drain(1'b0);
    do_reset();
    issue(2'b11, 32'h90, 32'h90, 1'b1, 1'b1);
    chk("halt_dual_2", 64'(halted), 64'd0);
    issue(2'b11, 32'h90, 32'h90, 1'b1, 1'b1);
    chk("halt_dual_4", 64'(halted), 64'd1);
    drain(1'b0);

    // Backpressure toggling
    do_reset();
    for (int i = 0; i < 6; i++) begin
      out_ready = i[0];
      issue(2'b11, 32'h300 + 32'(i * 8), 32'h304 + 32'(i * 8), 1'b1, 1'b0);
    end
    drain(1'b1);
    chk("bp_retired", retired, 64'd12);

    // Fill then overflow
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) issue(2'b11, 32'h400 + 32'(i * 8), 32'h404 + 32'(i * 8), 1'b1, 1'b0);
    chk("fill_overflow_clear", 64'(overflow), 64'd0);
    issue(2'b11, 32'h500, 32'h504, 1'b0, 1'b0);
    chk("ovf_overflow", 64'(overflow), 64'd1);
    chk("ovf_drop_count", 64'(drop_count), 64'd2);
    chk("ovf_retired", retired, 64'd18);
    drain(1'b0);
    issue(2'b01, 32'h600, 32'h0, 1'b1, 1'b0);
    drain(1'b0);

    // Full FIFO with simultaneous pop and push: push must drop
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) issue(2'b11, 32'h700 + 32'(i * 8), 32'h704 + 32'(i * 8), 1'b1, 1'b0);
    out_ready = 1'b1;
    issue(2'b01, 32'h800, 32'h0, 1'b0, 1'b0);
    chk("fullpop_drop_count", 64'(drop_count), 64'd3);
    drain(1'b0);
    chk("fullpop_retired", retired, 64'd36);

    // Reset mid-stream discards queued records
    out_ready = 1'b0;
    issue(2'b11, 32'h900, 32'h904, 1'b0, 1'b0);
    issue(2'b11, 32'h908, 32'h90c, 1'b0, 1'b0);
    issue(2'b01, 32'h910, 32'h0, 1'b0, 1'b0);
    chk("mid_out_valid_before", 64'(out_valid), 64'd1);
    do_reset();
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_retired", retired, 64'd0);
    chk("mid_overflow", 64'(overflow), 64'd0);
    chk("mid_drop_count", 64'(drop_count), 64'd0);
    out_ready = 1'b1;
    issue(2'b01, 32'hA00, 32'h0, 1'b1, 1'b0);
    drain(1'b0);
    chk("final_retired", retired, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
